// File: rtl/daw_pkg.sv
// ============================================================================
// daw_pkg -- shared sample types, scheduler state encoding and saturation helper
// Revision 1.0
// ============================================================================
`default_nettype none

package daw_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

  // Clamp a wide signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_accum.sv
// ============================================================================
// sat_accum -- one channel's clear/add accumulator with a saturated view of the running sum
// Revision 1.0
// ============================================================================
`default_nettype none

module sat_accum
  import daw_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = SAMPLE_W + 3
) (
  input  logic                       mclk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       add_i,
  input  logic signed [SAMPLE_W-1:0] din_i,
  output logic signed [SAMPLE_W-1:0] sat_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] w_addend;
  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    w_addend = add_i ? ACC_W'(din_i) : '0;
    w_sum    = acc_q + w_addend;
    acc_d    = clear_i ? '0 : w_sum;
  end

  // The saturated view includes the word being added this cycle, so the
  // final sum can be registered on the same edge that absorbs the last word.
  assign sat_o = SAMPLE_W'(saturate(64'(w_sum), SAMPLE_W));

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/track_mix_scheduler.sv
// ============================================================================
// track_mix_scheduler -- per-frame record/read/mix scheduler owning one shared sample RAM port
// Revision 1.0
// ============================================================================
`default_nettype none

module track_mix_scheduler
  import daw_pkg::*;
#(
  parameter int NUM_TRACKS  = 4,
  parameter int SAMPLE_W    = 16,
  parameter int ADDR_W      = 16,
  parameter int LOOP_LEN    = 2 ** ADDR_W,
  parameter int MEM_LATENCY = 2
) (
  input  logic                                   mclk_i,
  input  logic                                   rst_n_i,
  input  logic                                   frame_strobe_i,
  input  logic [SAMPLE_W-1:0]                    rx_data_l_i,
  input  logic [SAMPLE_W-1:0]                    rx_data_r_i,
  input  logic                                   play_en_i,
  input  logic                                   rec_en_i,
  input  logic [$clog2(NUM_TRACKS)-1:0]          rec_track_i,
  input  logic [NUM_TRACKS-1:0]                  track_mute_i,
  input  logic                                   rewind_i,
  output logic [$clog2(NUM_TRACKS)+ADDR_W-1:0]   mem_addr_o,
  output logic                                   mem_we_o,
  output logic                                   mem_re_o,
  output logic [2*SAMPLE_W-1:0]                  mem_wdata_o,
  input  logic [2*SAMPLE_W-1:0]                  mem_rdata_i,
  output logic signed [SAMPLE_W-1:0]             mix_l_o,
  output logic signed [SAMPLE_W-1:0]             mix_r_o,
  output logic                                   mix_valid_o,
  output logic [ADDR_W-1:0]                      frame_ptr_o,
  output logic                                   overrun_o
);

  localparam int TW    = $clog2(NUM_TRACKS);
  localparam int ACC_W = SAMPLE_W + TW + 1;

  sched_state_t                 state_q;
  logic [TW-1:0]                rd_cnt_q;
  logic [NUM_TRACKS-1:0]        mute_q;
  logic [ADDR_W-1:0]            ptr_q;
  logic                         rew_pend_q;
  logic                         overrun_q;
  logic                         mem_we_q;
  logic                         mem_re_q;
  logic [TW+ADDR_W-1:0]         mem_addr_q;
  logic [2*SAMPLE_W-1:0]        mem_wdata_q;
  logic signed [SAMPLE_W-1:0]   mix_l_q;
  logic signed [SAMPLE_W-1:0]   mix_r_q;
  logic                         mix_valid_q;
  logic [MEM_LATENCY-1:0]       pipe_vld_q;
  logic [MEM_LATENCY-1:0]       pipe_mute_q;

  logic [ADDR_W-1:0]            w_ptr_idle;
  logic [ADDR_W-1:0]            w_ptr_next;
  logic                         w_drain_done;
  logic                         w_acc_clear;
  logic                         w_acc_add;
  logic signed [SAMPLE_W-1:0]   w_sat_l;
  logic signed [SAMPLE_W-1:0]   w_sat_r;

  // A rewind coinciding with an accepted strobe addresses the whole frame at 0.
  assign w_ptr_idle = rewind_i ? '0 : ptr_q;

  always_comb begin
    w_ptr_next = ptr_q + ADDR_W'(1);
    if (rew_pend_q || rewind_i) begin
      w_ptr_next = '0;
    end else if (ptr_q == ADDR_W'(LOOP_LEN - 1)) begin
      w_ptr_next = '0;
    end
  end

  // The last read word sits at the pipe output once nothing remains behind it.
  assign w_drain_done = pipe_vld_q[MEM_LATENCY-1] && ((pipe_vld_q << 1) == '0);
  assign w_acc_clear  = (state_q == S_IDLE);
  assign w_acc_add    = pipe_vld_q[MEM_LATENCY-1] && !pipe_mute_q[MEM_LATENCY-1];

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_vld_q  <= '0;
      pipe_mute_q <= '0;
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_mute_q[i] <= pipe_mute_q[i-1];
      end
      pipe_vld_q[0]  <= mem_re_q;
      pipe_mute_q[0] <= mute_q[rd_cnt_q];
    end
  end

  sat_accum #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_acc_l (
    .mclk_i  (mclk_i),
    .rst_n_i (rst_n_i),
    .clear_i (w_acc_clear),
    .add_i   (w_acc_add),
    .din_i   ($signed(mem_rdata_i[2*SAMPLE_W-1:SAMPLE_W])),
    .sat_o   (w_sat_l)
  );

  sat_accum #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_acc_r (
    .mclk_i  (mclk_i),
    .rst_n_i (rst_n_i),
    .clear_i (w_acc_clear),
    .add_i   (w_acc_add),
    .din_i   ($signed(mem_rdata_i[SAMPLE_W-1:0])),
    .sat_o   (w_sat_r)
  );

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      mute_q      <= '0;
      ptr_q       <= '0;
      rew_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      mix_valid_q <= 1'b0;
      if (frame_strobe_i && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (rewind_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        rew_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (rewind_i) begin
            ptr_q <= '0;
          end
          if (frame_strobe_i) begin
            if (play_en_i) begin
              state_q     <= S_REC;
              mem_we_q    <= rec_en_i;
              mem_addr_q  <= {rec_track_i, w_ptr_idle};
              mem_wdata_q <= {rx_data_l_i, rx_data_r_i};
            end else begin
              state_q     <= S_DONE;
              mix_l_q     <= '0;
              mix_r_q     <= '0;
              mix_valid_q <= 1'b1;
            end
          end
        end

        S_REC: begin
          state_q    <= S_READ;
          mute_q     <= track_mute_i;
          mem_re_q   <= 1'b1;
          mem_addr_q <= {TW'(0), ptr_q};
          rd_cnt_q   <= '0;
        end

        S_READ: begin
          if (rd_cnt_q == TW'(NUM_TRACKS - 1)) begin
            state_q  <= S_DRAIN;
            mem_re_q <= 1'b0;
          end else begin
            rd_cnt_q   <= rd_cnt_q + TW'(1);
            mem_addr_q <= {rd_cnt_q + TW'(1), ptr_q};
          end
        end

        S_DRAIN: begin
          if (w_drain_done) begin
            state_q     <= S_DONE;
            mix_l_q     <= w_sat_l;
            mix_r_q     <= w_sat_r;
            mix_valid_q <= 1'b1;
            ptr_q       <= w_ptr_next;
            rew_pend_q  <= 1'b0;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          if (rewind_i) begin
            ptr_q <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mix_l_o     = mix_l_q;
  assign mix_r_o     = mix_r_q;
  assign mix_valid_o = mix_valid_q;
  assign frame_ptr_o = ptr_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_track_mix_scheduler.sv
// ============================================================================
// tb_track_mix_scheduler -- randomized bench with a behavioural RAM and mix model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_track_mix_scheduler;
  import daw_pkg::*;

  localparam int NT = 4;
  localparam int SW = 16;
  localparam int AW = 16;
  localparam int LL = 4;
  localparam int ML = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_strobe;
  logic [SW-1:0]      rx_l;
  logic [SW-1:0]      rx_r;
  logic               play_en;
  logic               rec_en;
  logic [1:0]         rec_track;
  logic [NT-1:0]      track_mute;
  logic               rewind;
  logic [AW+1:0]      mem_addr;
  logic               mem_we;
  logic               mem_re;
  logic [2*SW-1:0]    mem_wdata;
  logic [2*SW-1:0]    mem_rdata;
  logic [SW-1:0]      mix_l;
  logic [SW-1:0]      mix_r;
  logic               mix_valid;
  logic [AW-1:0]      frame_ptr;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  logic [31:0] ram [int];
  logic [31:0] rd_s1;

  always #5 clk = ~clk;

  track_mix_scheduler #(
    .NUM_TRACKS  (NT),
    .SAMPLE_W    (SW),
    .ADDR_W      (AW),
    .LOOP_LEN    (LL),
    .MEM_LATENCY (ML)
  ) dut (
    .mclk_i         (clk),
    .rst_n_i        (rst_n),
    .frame_strobe_i (frame_strobe),
    .rx_data_l_i    (rx_l),
    .rx_data_r_i    (rx_r),
    .play_en_i      (play_en),
    .rec_en_i       (rec_en),
    .rec_track_i    (rec_track),
    .track_mute_i   (track_mute),
    .rewind_i       (rewind),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_re_o       (mem_re),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mix_l_o        (mix_l),
    .mix_r_o        (mix_r),
    .mix_valid_o    (mix_valid),
    .frame_ptr_o    (frame_ptr),
    .overrun_o      (overrun)
  );

  function automatic logic [31:0] mem_rd(input int a);
    if (ram.exists(a)) return ram[a];
    return 32'h0;
  endfunction

  function automatic int key(input int trk, input int p);
    return (trk << 16) | p;
  endfunction

  // Two-cycle synchronous RAM: data read at one edge appears after the next.
  always @(posedge clk) begin
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    rd_s1     <= mem_re ? mem_rd(int'(mem_addr)) : 32'hxxxx_xxxx;
    mem_rdata <= rd_s1;
  end

  function automatic logic [15:0] clamp16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic model_mix(input int p, input logic [3:0] mute, input bit rec, input int trk,
                           input logic [31:0] rxw, output logic [15:0] el, output logic [15:0] er);
    int sl;
    int sr;
    logic [31:0] w;
    sl = 0;
    sr = 0;
    for (int k = 0; k < NT; k++) begin
      w = (rec && k == trk) ? rxw : mem_rd(key(k, p));
      if (!mute[k]) begin
        sl += int'($signed(w[31:16]));
        sr += int'($signed(w[15:0]));
      end
    end
    el = clamp16(sl);
    er = clamp16(sr);
  endtask

  // Drives one strobe (entered at a negedge) and watches the frame until mix_valid.
  task automatic launch_frame(input bit play, input bit rec, input int trk, input logic [31:0] rxw,
                              input logic [3:0] mute, input int rew_cyc,
                              output int lat, output logic [15:0] ml, output logic [15:0] mr,
                              output logic [15:0] ptr, output int nwr, output logic [17:0] waddr,
                              output logic [31:0] wdata, output int nre);
    lat = -1; nwr = 0; nre = 0; ml = '0; mr = '0; ptr = '0; waddr = '0; wdata = '0;
    play_en = play; rec_en = rec; rec_track = trk[1:0];
    rx_l = rxw[31:16]; rx_r = rxw[15:0]; track_mute = mute;
    frame_strobe = 1'b1;
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      @(negedge clk);
      frame_strobe = 1'b0;
      rewind = (c == rew_cyc);
      if (mem_we) begin nwr++; waddr = mem_addr; wdata = mem_wdata; end
      if (mem_re) nre++;
      if (mix_valid) begin lat = c; ml = mix_l; mr = mix_r; ptr = frame_ptr; end
    end
    rewind = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_we, mem_re, mix_valid, overrun} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_we, mem_re, mix_valid, overrun});
    end
    checks++;
    if ({mix_l, mix_r} !== 32'h0) begin
      failures++; $display("FAIL reset_mix got=%h exp=00000000", {mix_l, mix_r});
    end
    checks++;
    if (frame_ptr !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_regs got ptr=%0d addr=%h wdata=%h exp=0", frame_ptr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic();
    stereo_t s;
    int lat, nwr, nre; logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    s.l = 16'sd1000; s.r = -16'sd1000; ram[key(0, 0)] = s;
    s.l = 16'sd2000; s.r = -16'sd500;  ram[key(1, 0)] = s;
    model_mix(m_ptr, 4'b0000, 1'b0, 0, 32'h0, el, er);
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    m_ptr = (m_ptr + 1) % LL;
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++;
    if ({ml, mr} !== {el, er}) begin failures++; $display("FAIL basic_mix got=%h exp=%h", {ml, mr}, {el, er}); end
    checks++;
    if (ptr !== 16'(m_ptr)) begin failures++; $display("FAIL basic_ptr got=%0d exp=%0d", ptr, m_ptr); end
    checks++;
    if (nre !== NT || nwr !== 0) begin failures++; $display("FAIL basic_access got re=%0d we=%0d exp re=4 we=0", nre, nwr); end
  endtask

  task automatic test_saturation();
    logic [3:0] masks [3];
    int lat, nwr, nre; logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    masks[0] = 4'b0000; masks[1] = 4'b0011; masks[2] = 4'b0111;
    for (int p = 0; p < LL; p++)
      for (int k = 0; k < NT; k++) ram[key(k, p)] = {16'sd30000, -16'sd30000};
    for (int i = 0; i < 3; i++) begin
      model_mix(m_ptr, masks[i], 1'b0, 0, 32'h0, el, er);
      launch_frame(1'b1, 1'b0, 0, 32'h0, masks[i], -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
      m_ptr = (m_ptr + 1) % LL;
      checks++;
      if ({ml, mr} !== {el, er} || lat !== 8) begin
        failures++; $display("FAIL sat_mix mask=%b got=%h lat=%0d exp=%h lat=8", masks[i], {ml, mr}, lat, {el, er});
      end
      checks++;
      if (ptr !== 16'(m_ptr)) begin failures++; $display("FAIL sat_ptr got=%0d exp=%0d", ptr, m_ptr); end
    end
  endtask

  task automatic test_record();
    int lat, nwr, nre; logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    for (int k = 0; k < NT; k++) ram[key(k, m_ptr)] = 32'h0;
    model_mix(m_ptr, 4'b0000, 1'b1, 2, 32'h1234_FEDC, el, er);
    launch_frame(1'b1, 1'b1, 2, 32'h1234_FEDC, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    checks++;
    if (nwr !== 1 || wa !== 18'(key(2, m_ptr)) || wd !== 32'h1234_FEDC) begin
      failures++; $display("FAIL rec_write got n=%0d addr=%h data=%h exp n=1 addr=%h data=1234fedc", nwr, wa, wd, 18'(key(2, m_ptr)));
    end
    m_ptr = (m_ptr + 1) % LL;
    checks++;
    if ({ml, mr} !== {el, er}) begin failures++; $display("FAIL rec_mix got=%h exp=%h", {ml, mr}, {el, er}); end
  endtask

  task automatic test_overrun();
    int nvalid; logic [15:0] ptr, ml, mr, el, er;
    nvalid = 0; ptr = '0; ml = '0; mr = '0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b exp=0", overrun); end
    for (int k = 0; k < NT; k++) ram[key(k, m_ptr)] = $urandom;
    model_mix(m_ptr, 4'b0000, 1'b0, 0, 32'h0, el, er);
    play_en = 1'b1; rec_en = 1'b0; track_mute = 4'b0000; frame_strobe = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      frame_strobe = (c == 3);
      if (mix_valid) begin nvalid++; ptr = frame_ptr; ml = mix_l; mr = mix_r; end
    end
    m_ptr = (m_ptr + 1) % LL;
    checks++;
    if (nvalid !== 1) begin failures++; $display("FAIL ovr_valid_count got=%0d exp=1", nvalid); end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++;
    if (ptr !== 16'(m_ptr) || {ml, mr} !== {el, er}) begin
      failures++; $display("FAIL ovr_frame got ptr=%0d mix=%h exp ptr=%0d mix=%h", ptr, {ml, mr}, m_ptr, {el, er});
    end
  endtask

  task automatic test_wrap_rewind();
    int lat, nwr, nre, guard; logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    guard = 0;
    while (m_ptr != LL - 1 && guard < 8) begin
      launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
      m_ptr = (m_ptr + 1) % LL; guard++;
    end
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    m_ptr = 0;
    checks++;
    if (ptr !== 16'd0 || lat !== 8) begin failures++; $display("FAIL wrap_ptr got=%0d lat=%0d exp=0 lat=8", ptr, lat); end
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    m_ptr = 1;
    checks++;
    if (ptr !== 16'd1) begin failures++; $display("FAIL wrap_next got=%0d exp=1", ptr); end
    for (int k = 0; k < NT; k++) ram[key(k, 1)] = $urandom;
    model_mix(1, 4'b1000, 1'b0, 0, 32'h0, el, er);
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b1000, 3, lat, ml, mr, ptr, nwr, wa, wd, nre);
    m_ptr = 0;
    checks++;
    if (ptr !== 16'd0 || {ml, mr} !== {el, er}) begin
      failures++; $display("FAIL rewind_busy got ptr=%0d mix=%h exp ptr=0 mix=%h", ptr, {ml, mr}, {el, er});
    end
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    checks++;
    if (frame_ptr !== 16'd0) begin failures++; $display("FAIL rewind_idle got=%0d exp=0", frame_ptr); end
    m_ptr = 0;
  endtask

  task automatic test_play_off();
    int lat, nwr, nre; logic [15:0] ml, mr, ptr; logic [17:0] wa; logic [31:0] wd;
    for (int k = 0; k < NT; k++) ram[key(k, m_ptr)] = 32'h0100_0200;
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    m_ptr = (m_ptr + 1) % LL;
    launch_frame(1'b0, 1'b1, 1, 32'h5555_AAAA, 4'b0000, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    checks++;
    if ({ml, mr} !== 32'h0 || lat < 0) begin failures++; $display("FAIL off_mix got=%h lat=%0d exp=00000000", {ml, mr}, lat); end
    checks++;
    if (ptr !== 16'(m_ptr) || nre !== 0 || nwr !== 0) begin
      failures++; $display("FAIL off_noaccess got ptr=%0d re=%0d we=%0d exp ptr=%0d re=0 we=0", ptr, nre, nwr, m_ptr);
    end
  endtask

  task automatic test_random();
    int lat, nwr, nre, trk; bit rec; logic [3:0] mute; logic [31:0] rxw;
    logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < NT; k++) ram[key(k, m_ptr)] = $urandom;
      mute = 4'($urandom); rec = 1'($urandom); trk = int'($urandom_range(0, NT - 1)); rxw = $urandom;
      model_mix(m_ptr, mute, rec, trk, rxw, el, er);
      launch_frame(1'b1, rec, trk, rxw, mute, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
      m_ptr = (m_ptr + 1) % LL;
      checks++;
      if ({ml, mr} !== {el, er} || lat !== 8) begin
        failures++; $display("FAIL rand_mix f=%0d got=%h lat=%0d exp=%h lat=8", f, {ml, mr}, lat, {el, er});
      end
      checks++;
      if (ptr !== 16'(m_ptr) || nwr !== int'(rec) || nre !== NT) begin
        failures++; $display("FAIL rand_ctl f=%0d got ptr=%0d we=%0d re=%0d exp ptr=%0d we=%0d re=4", f, ptr, nwr, nre, m_ptr, rec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nwr, nre, guard; logic [15:0] ml, mr, ptr, el, er; logic [17:0] wa; logic [31:0] wd;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    play_en = 1'b1; rec_en = 1'b0; track_mute = 4'b0000; frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    guard = 0;
    while (mem_re !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_re, mem_we, mix_valid, overrun} !== 4'b0 || guard >= 10) begin
      failures++; $display("FAIL rst_mid_flags got=%b guard=%0d exp=0000", {mem_re, mem_we, mix_valid, overrun}, guard);
    end
    checks++;
    if ({mix_l, mix_r} !== 32'h0 || frame_ptr !== '0) begin
      failures++; $display("FAIL rst_mid_regs got mix=%h ptr=%0d exp 0", {mix_l, mix_r}, frame_ptr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    for (int k = 0; k < NT; k++) ram[key(k, 0)] = $urandom;
    model_mix(0, 4'b0010, 1'b0, 0, 32'h0, el, er);
    launch_frame(1'b1, 1'b0, 0, 32'h0, 4'b0010, -1, lat, ml, mr, ptr, nwr, wa, wd, nre);
    checks++;
    if ({ml, mr} !== {el, er} || lat !== 8 || ptr !== 16'd1) begin
      failures++; $display("FAIL rst_recover got mix=%h lat=%0d ptr=%0d exp mix=%h lat=8 ptr=1", {ml, mr}, lat, ptr, {el, er});
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_strobe = 1'b0; rx_l = '0; rx_r = '0; play_en = 1'b0;
    rec_en = 1'b0; rec_track = '0; track_mute = '0; rewind = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_record();
    test_overrun();
    test_wrap_rewind();
    test_play_off();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
